// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier with signed/unsigned mode,
// early termination on a zero multiplier and a busy/done handshake.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FINISH
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               neg;

  logic               x_neg;
  logic               y_neg;
  logic [WIDTH-1:0]   x_abs;
  logic [WIDTH-1:0]   y_abs;
  logic               load;
  logic               step;

  // |min| = 2^(WIDTH-1) still fits as an unsigned WIDTH-bit value
  assign x_neg = signed_mode & x[WIDTH-1];
  assign y_neg = signed_mode & y[WIDTH-1];
  assign x_abs = x_neg ? WIDTH'(-x) : x;
  assign y_abs = y_neg ? WIDTH'(-y) : y;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (mplier != '0 && count < CW'(WIDTH)) begin
          step = 1'b1;
        end else begin
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      count   <= '0;
      neg     <= 1'b0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == FINISH);
      if (load) begin
        mcand  <= {{WIDTH{1'b0}}, x_abs};
        mplier <= y_abs;
        acc    <= '0;
        count  <= '0;
        neg    <= x_neg ^ y_neg;
      end
      if (step) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mplier <= mplier >> 1;
        mcand  <= mcand << 1;
        count  <= count + CW'(1);
      end
      if (state == FINISH) begin
        product <= neg ? (2*WIDTH)'(-acc) : acc;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed checks on an 8-bit multiplier plus a 16-bit random
// sweep against an arithmetic reference.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sm;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [15:0] product;
  logic        busy;
  logic        done;

  logic        start16;
  logic        sm16;
  logic [15:0] x16;
  logic [15:0] y16;
  logic [31:0] product16;
  logic        busy16;
  logic        done16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (sm),
    .x           (x),
    .y           (y),
    .product     (product),
    .busy        (busy),
    .done        (done)
  );

  seq_multiplier #(.WIDTH(16)) u_dut16 (
    .clk         (clk),
    .reset       (reset),
    .start       (start16),
    .signed_mode (sm16),
    .x           (x16),
    .y           (y16),
    .product     (product16),
    .busy        (busy16),
    .done        (done16)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after E0.
  task automatic issue8(input logic m,
                        input logic [7:0] a,
                        input logic [7:0] b);
    sm    = m;
    x     = a;
    y     = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x     = 8'($urandom);
    y     = 8'($urandom);
    sm    = 1'($urandom);
  endtask

  task automatic wait8(input string tag,
                       input logic [15:0] exp_p,
                       input int exp_lat,
                       input int inject);
    int lat  = 0;
    int bcnt = 0;
    bit seen = 0;
    if (busy) bcnt++;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == inject) begin
        start = 1'b1;
        sm    = 1'b1;
        x     = 8'h02;
        y     = 8'h03;
      end else begin
        start = 1'b0;
      end
      if (busy) bcnt++;
      if (done) seen = 1;
    end
    check({tag, "_done"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, "_prod"}, 64'(product), 64'(exp_p));
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_busy"}, 64'(bcnt), 64'(exp_lat));
    end
  endtask

  task automatic op16(input logic m,
                      input logic [15:0] a,
                      input logic [15:0] b);
    logic [31:0] exp_p;
    logic [15:0] ay;
    int n   = 0;
    int lat = 0;
    bit seen = 0;
    if (m) exp_p = 32'($signed(a) * $signed(b));
    else   exp_p = 32'(a) * 32'(b);
    ay = (m && b[15]) ? 16'(-b) : b;
    for (int i = 0; i < 16; i++) begin
      if (ay[i]) n = i + 1;
    end
    sm16    = m;
    x16     = a;
    y16     = b;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done16) seen = 1;
    end
    check("r16_done", 64'(seen), 64'd1);
    check("r16_prod", 64'(product16), 64'(exp_p));
    check("r16_lat", 64'(lat), 64'(n + 2));
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    sm      = 1'b0;
    x       = '0;
    y       = '0;
    start16 = 1'b0;
    sm16    = 1'b0;
    x16     = '0;
    y16     = '0;
    @(negedge clk);
    check("rst_prod", 64'(product), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    issue8(1'b0, 8'd13, 8'd11);
    wait8("u13x11", 16'h008F, 6, -1);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);

    issue8(1'b0, 8'hFF, 8'hFF);
    wait8("uffxff", 16'hFE01, 10, -1);
    issue8(1'b0, 8'hFF, 8'h00);
    wait8("uffx0", 16'h0000, 2, -1);

    issue8(1'b1, 8'hFD, 8'd5);
    wait8("s_m3x5", 16'hFFF1, 5, -1);
    issue8(1'b1, 8'h80, 8'h80);
    wait8("s_minxmin", 16'h4000, 10, -1);
    issue8(1'b1, 8'h7F, 8'hFF);
    wait8("s_127xm1", 16'hFF81, 3, -1);

    // start while busy is ignored
    issue8(1'b0, 8'd13, 8'd11);
    wait8("ign", 16'h008F, 6, 3);

    // start in the done cycle is accepted
    issue8(1'b1, 8'hF6, 8'd7);
    check("b2b_done_drop", 64'(done), 64'd0);
    wait8("b2b", 16'hFFBA, 5, -1);

    // reset mid-operation
    issue8(1'b0, 8'hFF, 8'hFF);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_prod", 64'(product), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue8(1'b0, 8'd13, 8'd11);
    wait8("post_rst", 16'h008F, 6, -1);

    for (int i = 0; i < 1000; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom);
      b = 16'($urandom) >> $urandom_range(0, 16);
      if (i % 7 == 0) b = 16'h8000;
      op16(1'($urandom), a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-and-add multiplier for the processor datapath. It is the next-generation replacement for the fixed 8-bit multiplier. It adds a configurable operand width, a per-operation signed/unsigned mode, early termination once the remaining multiplier bits are zero, and a busy/done handshake. The execute stage issues it with a one-cycle start and waits for done.

## Interface
- WIDTH, 8: operand width in bits, ≥ 2; product is 2*WIDTH bits.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clock clk.
- start  in  1  request pulse; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- x  in  WIDTH  multiplicand; sampled with start.
- y  in  WIDTH  multiplier; sampled with start.
- product  out  2*WIDTH  result register; holds last result until next FINISH.
- busy  out  1  high in BUSY and FINISH states.
- done  out  1  one-cycle pulse, high the cycle after FINISH writes product.

## Operation
- States: IDLE, BUSY, FINISH. Reset → IDLE; product=0, done=0, busy=0, internal registers 0.
- IDLE, start=1: latch operands and mode, clear accumulator and count, then go to BUSY.
  - Unsigned mode: mcand = zero-extended x; mplier = y.
  - Signed mode: mcand = zero-extended |x|; mplier = |y|; latch neg = x[MSB]^y[MSB].
  - |−2^(WIDTH−1)| = 2^(WIDTH−1), which fits in WIDTH unsigned bits. No overflow case exists.
- IDLE, start=0: hold. done returns to 0.
- BUSY, each edge with mplier≠0 and count<WIDTH:
  - if mplier[0]=1, acc += mcand (2*WIDTH-bit, no carry-out possible);
  - mplier >>= 1; mcand <<= 1; count += 1.
- BUSY, mplier=0 or count=WIDTH: go to FINISH. No accumulation occurs on this edge.
- FINISH edge:
  - product ← neg ? (~acc + 1) : acc. neg is forced to 0 in unsigned mode.
  - done ← 1; then go to IDLE.
- start while busy=1 is ignored. No queuing, and latched operands are unaffected.
- start in the same cycle done=1 (state IDLE) is accepted normally. done still drops after one cycle.
- Inputs x, y and signed_mode may change freely after the start edge.
- reset asserted at any point: immediate return to the reset values above. Any in-flight result is discarded and product is cleared.

## Timing
- Edge E0 samples start. Let n = bit index of MSB of the latched mplier, plus 1 (n=0 when mplier=0).
- BUSY lasts n+1 edges (E1…E(n+1)). The FINISH edge is E(n+2). done and the new product are visible after E(n+2).
- Start-to-done latency = n+2 cycles.
  - Minimum 2 cycles (y=0).
  - Maximum WIDTH+2 cycles (mplier MSB set, including signed y = −2^(WIDTH−1)).
- busy rises after E0 and falls after E(n+2), the same edge on which done rises. done falls after E(n+3).
- Throughput: a new start may be issued in the done cycle. Back-to-back spacing is latency+0 cycles.

## Test plan
- Unsigned, WIDTH=8: x=13, y=11 (n=4) → product=0x008F, done 6 cycles after start, busy high for exactly 6 cycles.
- Unsigned: x=0xFF, y=0xFF → product=0xFE01 at 10 cycles. Then x=0xFF, y=0 → product=0x0000 at 2 cycles.
- Signed:
  - x=−3 (0xFD), y=5 → product=0xFFF1.
  - x=−128, y=−128 → product=0x4000 after 10 cycles.
  - x=127, y=−1 → 0xFF81.
- Start pulsed at cycle 3 of a busy operation with different operands → ignored; original result delivered at the original cycle. A start in the done cycle → second result correct, with latency per rule.
- Reset asserted mid-BUSY (cycle 4 of 0xFF*0xFF) → product=0, busy=0, done=0 immediately. Next start completes normally.
- WIDTH=16 instance, random signed/unsigned operands (≥1000) vs reference model → all products match; latency = n+2 every time.
